pico_result_requester: RTL and testbench
========================================

PICO_RESULT_REQUESTER -- requirements
Module: pico_result_requester

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the maximum number of clk cycles spent in any wait state.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16), giving the number of result-FIFO entries.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port req, input, 1 bit: request one result byte from the PicoBlaze program.
REQ-006 The block SHALL have port pico_done, input, 1 bit: done flag written by the PicoBlaze program (port 40h, bit 0).
REQ-007 The block SHALL have port pico_data, input, 8 bits: result byte written by the PicoBlaze program (port 80h).
REQ-008 The block SHALL have port rd_en, input, 1 bit: pop the FIFO head.
REQ-009 The block SHALL have port start_pico, output, 1 bit: start level to the PicoBlaze input port 00h.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port dout, output, 8 bits: FIFO head, first-word fall-through.
REQ-012 The block SHALL have port empty, output, 1 bit: FIFO holds no entries.
REQ-013 The block SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-014 The block SHALL have port count, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-015 The block SHALL have port timeout_err, output, 1 bit: sticky timeout flag.

Function
REQ-016 The FSM SHALL have four states: IDLE, ASSERT, WAIT_DONE and RELEASE, and all outputs SHALL be registered.
REQ-017 In IDLE, req=1 with full=0 SHALL move the FSM to ASSERT, clear timeout_err and clear the timer; req with full=1 SHALL be ignored.
REQ-018 req SHALL be ignored in every state other than IDLE, with no queuing.
REQ-019 start_pico SHALL be 1 in ASSERT and WAIT_DONE and 0 in IDLE and RELEASE, so a req accepted in cycle N drives start_pico=1 in cycle N+1.
REQ-020 ASSERT SHALL last exactly one cycle and then move the FSM to WAIT_DONE.
REQ-021 done_edge SHALL be pico_done=1 while a registered copy of pico_done=0, and the registered copy SHALL reset to 1 so that a pico_done held high through reset never produces an edge.
REQ-022 In WAIT_DONE, done_edge SHALL write pico_data of that same cycle into the FIFO and move the FSM to RELEASE, so start_pico=0, empty=0 and dout are valid in the following cycle.
REQ-023 In RELEASE, pico_done=0 SHALL move the FSM to IDLE, with no write and no change to start_pico.
REQ-024 The timer SHALL be cleared on every state entry and increment once per cycle in WAIT_DONE and RELEASE; at TIMEOUT_CYCLES-1 without the exit condition the FSM SHALL set timeout_err=1 and move to IDLE with no FIFO write.
REQ-025 The timer SHALL saturate and SHALL never wrap.
REQ-026 The FIFO SHALL be a circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
REQ-027 rd_en with empty=0 SHALL pop the head in the same cycle; rd_en with empty=1 SHALL be ignored.
REQ-028 A simultaneous write and pop SHALL leave count unchanged and preserve order.
REQ-029 Because a request is accepted only when full=0 and only one request is outstanding at a time, the FIFO SHALL never be written while full.
REQ-030 dout SHALL hold its last value when the FIFO becomes empty.
REQ-031 reset_n=0 mid-transaction SHALL abort the transaction, drop start_pico in the next cycle and discard any pending capture.

Reset
REQ-032 While reset_n=0 at a clk edge, the block SHALL enter IDLE with start_pico=0, busy=0, dout=8'h00, empty=1, full=0, count=0, timeout_err=0, timer=0, both pointers=0 and the registered pico_done copy=1.

Verification
REQ-033 Basic handshake: req in cycle 0, pico_data=8'h5A with pico_done rising in cycle 10, then pico_done falling in cycle 14 -> start_pico=1 in cycles 1-10, 0 from cycle 11; dout=5A and empty=0 in cycle 11; busy=0 from cycle 15.
REQ-034 Stale done: pico_done held at 1 from reset, then req -> no capture while pico_done stays high; after pico_done goes 0 then 1 with data 8'h33, exactly one entry 33 is captured.
REQ-035 Timeout: TIMEOUT_CYCLES=16, req and pico_done never rises -> timeout_err=1, start_pico=0 and busy=0 after 16 WAIT_DONE cycles; count=0; the next accepted req clears timeout_err.
REQ-036 FIFO fill and wrap: four transactions with data 01..04 -> full=1 and count=4, and a fifth req is ignored (start_pico stays 0); one pop then one transaction with 05 -> pops return 02,03,04,05 in order.
REQ-037 Simultaneous capture and pop: count=2 with a done_edge and rd_en in the same cycle -> count stays 2 and order is preserved.
REQ-038 Reset mid-operation: reset_n=0 for one cycle during WAIT_DONE -> start_pico=0 and all REQ-032 values the next cycle, and a later pico_done edge writes nothing.

Source files
------------

// File: rtl/pico_result_requester.sv
// pico_result_requester
//   Requests one result byte at a time from a PicoBlaze program and queues the
//   captured bytes in a small first-word-fall-through FIFO.
//
//   Handshake: an accepted req raises start_pico. The program answers with a
//   rising pico_done while pico_data holds the result. The byte is captured on
//   that edge and start_pico drops. The FSM then waits for pico_done to fall
//   before it accepts another request. Each wait is bounded by TIMEOUT_CYCLES.
//   On expiry the FSM returns to idle and raises the sticky timeout_err.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   req                   request one result byte (honoured only in IDLE, FIFO not full)
//   pico_done, pico_data  done flag and result byte from the PicoBlaze program
//   rd_en                 pop the FIFO head (ignored when empty)
//   start_pico            start level to the PicoBlaze program
//   busy                  FSM not in IDLE
//   dout, empty, full     FIFO head (fall-through) and status
//   count                 FIFO occupancy
//   timeout_err           sticky; cleared by the next accepted req
module pico_result_requester #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req,
    input  logic                          pico_done,
    input  logic [7:0]                    pico_data,
    input  logic                          rd_en,
    output logic                          start_pico,
    output logic                          busy,
    output logic [7:0]                    dout,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          timeout_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_DONE, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pico_done_q, pico_done_d;
    logic            timeout_err_q, timeout_err_d;
    logic            start_pico_q, start_pico_d;
    logic            busy_q, busy_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [CW-1:0]   count_q, count_d;
    logic            empty_q, empty_d, full_q, full_d;
    logic [7:0]      dout_q, dout_d;
    logic            done_edge, wr, pop;

    // The registered copy resets high, so a done flag that is already high
    // when reset is released never counts as a fresh edge.
    assign done_edge   = pico_done && !pico_done_q;
    assign pico_done_d = pico_done;

    // Control FSM and wait timer
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q;
        wr            = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !full_q) begin
                    state_d       = ASSERT;
                    timeout_err_d = 1'b0;
                end
            end
            ASSERT: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (done_edge) begin
                    wr      = 1'b1;
                    state_d = RELEASE;
                end else if (timer_q == TMAX) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            RELEASE: begin
                if (!pico_done) begin
                    state_d = IDLE;
                end else if (timer_q == TMAX) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Cleared on every state change, counts only in the wait states and
        // saturates at the expiry value.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == WAIT_DONE || state_q == RELEASE) && timer_q != TMAX) begin
            timer_d = timer_q + 1'b1;
        end

        start_pico_d = (state_d == ASSERT) || (state_d == WAIT_DONE);
        busy_d       = (state_d != IDLE);
    end

    // Result FIFO. dout is a register that always shows the head after the update.
    always_comb begin
        pop      = rd_en && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        rd_nxt   = rd_ptr_q + 1'b1;

        if (wr) begin
            mem_d[wr_ptr_q] = pico_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_nxt;

        unique case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            // Popping the last entry: the new head is the byte being written
            // this cycle. If nothing is written, dout keeps its old value.
            if (count_q == CW'(1)) begin
                if (wr) dout_d = pico_data;
            end else begin
                dout_d = mem_q[rd_nxt];
            end
        end else if (wr && empty_q) begin
            dout_d = pico_data;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            pico_done_q   <= 1'b1;
            timeout_err_q <= 1'b0;
            start_pico_q  <= 1'b0;
            busy_q        <= 1'b0;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            dout_q        <= 8'h00;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pico_done_q   <= pico_done_d;
            timeout_err_q <= timeout_err_d;
            start_pico_q  <= start_pico_d;
            busy_q        <= busy_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            dout_q        <= dout_d;
        end
    end

    assign start_pico  = start_pico_q;
    assign busy        = busy_q;
    assign dout        = dout_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign count       = count_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pico_result_requester.sv
// Testbench for pico_result_requester: directed handshake, stale-done, timeout,
// FIFO wrap, simultaneous capture/pop and reset scenarios, followed by random
// transactions checked against a queue-based model of the result FIFO.
module tb_pico_result_requester;

    localparam int TO    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n, req, pico_done, rd_en;
    logic [7:0]    pico_data;
    logic          start_pico, busy, empty, full, timeout_err;
    logic [7:0]    dout;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state for the random test
    logic [7:0] model_q [$];
    logic [7:0] exp_dout;

    pico_result_requester #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .pico_done(pico_done),
        .pico_data(pico_data), .rd_en(rd_en), .start_pico(start_pico),
        .busy(busy), .dout(dout), .empty(empty), .full(full),
        .count(count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction, with done raised after d WAIT_DONE cycles (d >= 1)
    task automatic transact(input logic [7:0] data, input int d);
        req = 1'b1; tick(); req = 1'b0;
        repeat (d) tick();
        pico_done = 1'b1; pico_data = data; tick();
        pico_done = 1'b0; tick(); tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick(); tick();
        n_checks++; if (start_pico !== 1'b0) begin n_fail++; $display("FAIL rst_start got %b exp 0", start_pico); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rst_dout got %h exp 00", dout); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b exp 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", full); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b exp 0", timeout_err); end
        reset_n = 1'b1; tick(); tick();
    endtask

    task automatic test_handshake();
        req = 1'b1; tick(); req = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            n_checks++; if (start_pico !== (c <= 10)) begin n_fail++; $display("FAIL hs_start c=%0d got %b exp %b", c, start_pico, c <= 10); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_busy c=%0d got %b exp 1", c, busy); end
            if (c == 11) begin
                n_checks++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL hs_dout got %h exp 5a", dout); end
                n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL hs_empty got %b exp 0", empty); end
            end
            if (c == 10) begin pico_done = 1'b1; pico_data = 8'h5A; end
            if (c == 14) pico_done = 1'b0;
            tick();
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_busy15 got %b exp 0", busy); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL hs_count got %0d exp 1", count); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL hs_pop_empty got %b exp 1", empty); end
        n_checks++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL hs_dout_hold got %h exp 5a", dout); end
    endtask

    task automatic test_stale();
        pico_done = 1'b1; reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        req = 1'b1; tick(); req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL stale_nocap c=%0d got %0d exp 0", c, count); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stale_busy c=%0d got %b exp 1", c, busy); end
        end
        pico_done = 1'b0; tick();
        pico_done = 1'b1; pico_data = 8'h33; tick();
        pico_done = 1'b0;
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stale_count got %0d exp 1", count); end
        n_checks++; if (dout !== 8'h33) begin n_fail++; $display("FAIL stale_dout got %h exp 33", dout); end
        n_checks++; if (start_pico !== 1'b0) begin n_fail++; $display("FAIL stale_start got %b exp 0", start_pico); end
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stale_idle got %b exp 0", busy); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stale_once got %0d exp 1", count); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stale_drain got %b exp 1", empty); end
    endtask

    task automatic test_timeout();
        req = 1'b1; tick(); req = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            n_checks++; if (busy !== 1'b1 || start_pico !== 1'b1 || timeout_err !== 1'b0) begin
                n_fail++; $display("FAIL to_wait c=%0d got busy=%b start=%b err=%b exp 1 1 0", c, busy, start_pico, timeout_err);
            end
            tick();
        end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b exp 1", timeout_err); end
        n_checks++; if (start_pico !== 1'b0) begin n_fail++; $display("FAIL to_start got %b exp 0", start_pico); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy got %b exp 0", busy); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL to_count got %0d exp 0", count); end
        tick(); tick();
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b exp 1", timeout_err); end
        req = 1'b1; tick(); req = 1'b0;
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear got %b exp 0", timeout_err); end
        n_checks++; if (start_pico !== 1'b1) begin n_fail++; $display("FAIL to_restart got %b exp 1", start_pico); end
        tick();
        pico_done = 1'b1; pico_data = 8'hAA; tick();
        pico_done = 1'b0; tick(); tick();
        n_checks++; if (count !== 3'd1 || dout !== 8'hAA) begin n_fail++; $display("FAIL to_after got count=%0d dout=%h exp 1 aa", count, dout); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    task automatic test_fill_wrap();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 1; i <= 4; i++) transact(8'(i), i);
        n_checks++; if (full !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL fill_full got full=%b count=%0d exp 1 4", full, count); end
        req = 1'b1; tick(); req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (start_pico !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fill_ignore c=%0d got start=%b busy=%b exp 0 0", c, start_pico, busy); end
            tick();
        end
        n_checks++; if (dout !== 8'h01) begin n_fail++; $display("FAIL fill_head got %h exp 01", dout); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_checks++; if (count !== 3'd3 || full !== 1'b0) begin n_fail++; $display("FAIL fill_pop got count=%0d full=%b exp 3 0", count, full); end
        transact(8'h05, 2);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (dout !== exp_seq[i]) begin n_fail++; $display("FAIL wrap_order i=%0d got %h exp %h", i, dout, exp_seq[i]); end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        n_checks++; if (empty !== 1'b1 || dout !== 8'h05) begin n_fail++; $display("FAIL wrap_end got empty=%b dout=%h exp 1 05", empty, dout); end
    endtask

    task automatic test_simul_capture_pop();
        transact(8'hA1, 1);
        transact(8'hA2, 3);
        req = 1'b1; tick(); req = 1'b0; tick();
        pico_done = 1'b1; pico_data = 8'hA3; rd_en = 1'b1; tick();
        pico_done = 1'b0; rd_en = 1'b0;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL sim_count got %0d exp 2", count); end
        n_checks++; if (dout !== 8'hA2) begin n_fail++; $display("FAIL sim_head got %h exp a2", dout); end
        tick(); tick();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_checks++; if (dout !== 8'hA3 || count !== 3'd1) begin n_fail++; $display("FAIL sim_next got %h cnt %0d exp a3 1", dout, count); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sim_empty got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        transact(8'h77, 1);
        req = 1'b1; tick(); req = 1'b0; tick(); tick();
        n_checks++; if (start_pico !== 1'b1) begin n_fail++; $display("FAIL rm_pre got %b exp 1", start_pico); end
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        n_checks++; if (start_pico !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL rm_ctrl got start=%b busy=%b err=%b exp 0 0 0", start_pico, busy, timeout_err);
        end
        n_checks++; if (dout !== 8'h00 || empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL rm_fifo got dout=%h empty=%b full=%b count=%0d exp 00 1 0 0", dout, empty, full, count);
        end
        tick();
        pico_done = 1'b1; pico_data = 8'hEE; tick(); tick();
        pico_done = 1'b0; tick();
        n_checks++; if (count !== 3'd0 || empty !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rm_nowrite got count=%0d empty=%b busy=%b exp 0 1 0", count, empty, busy);
        end
    endtask

    // One random-test cycle: apply the model's view of this cycle, then compare
    task automatic cyc(input logic wr_now, input logic [7:0] wdata);
        if (rd_en && model_q.size() > 0) void'(model_q.pop_front());
        if (wr_now) model_q.push_back(wdata);
        if (model_q.size() > 0) exp_dout = model_q[0];
        tick();
        n_checks++; if (count !== CW'(model_q.size())) begin n_fail++; $display("FAIL rnd_count got %0d exp %0d", count, model_q.size()); end
        n_checks++; if (empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH)) begin
            n_fail++; $display("FAIL rnd_flags got empty=%b full=%b exp size %0d", empty, full, model_q.size());
        end
        n_checks++; if (dout !== exp_dout) begin n_fail++; $display("FAIL rnd_dout got %h exp %h", dout, exp_dout); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        model_q.delete();
        exp_dout = 8'h00;
        for (int it = 0; it < 60; it++) begin
            if (model_q.size() == DEPTH) begin
                req = 1'b1; rd_en = 1'b0; cyc(1'b0, 8'h00); req = 1'b0;
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_full_ignore got %b exp 0", busy); end
                rd_en = 1'b1; cyc(1'b0, 8'h00);
                cyc(1'b0, 8'h00); rd_en = 1'b0;
            end else begin
                req = 1'b1; rd_en = 1'b0; cyc(1'b0, 8'h00); req = 1'b0;
                n_checks++; if (start_pico !== 1'b1) begin n_fail++; $display("FAIL rnd_accept got %b exp 1", start_pico); end
                repeat ($urandom_range(1, 8)) begin
                    rd_en = ($urandom_range(0, 3) == 0);
                    cyc(1'b0, 8'h00);
                end
                d = 8'($urandom);
                pico_done = 1'b1; pico_data = d; rd_en = ($urandom_range(0, 3) == 0);
                cyc(1'b1, d);
                pico_done = 1'b0; rd_en = ($urandom_range(0, 3) == 0);
                cyc(1'b0, 8'h00);
                rd_en = 1'b0;
                cyc(1'b0, 8'h00);
                n_checks++; if (busy !== 1'b0 || start_pico !== 1'b0) begin n_fail++; $display("FAIL rnd_idle got busy=%b start=%b exp 0 0", busy, start_pico); end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; pico_done = 1'b0; pico_data = 8'h00; rd_en = 1'b0;
        test_reset();
        test_handshake();
        test_stale();
        test_timeout();
        test_fill_wrap();
        test_simul_capture_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
